// File: rtl/hmmm_mem_pkg.sv
// Shared widths, sizes and the load-controller state type for the HMMM memory.
package hmmm_mem_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int WORD_WIDTH = 15;
  localparam int DATA_WIDTH = 8;
  localparam int MEM_WORDS  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/hmmm_mem_array.sv
// Storage array: one combinational read port, one clocked write port with enable.
// Contents are deliberately not reset so a program survives a controller reset.
module hmmm_mem_array
  import hmmm_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

  // Write one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hmmm_memory.sv
// Unified instruction/data memory for the HMMM processor with a host program
// load port. The controller holds the processor in reset until a load finishes.
module hmmm_memory
  import hmmm_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Adr,
  inout  wire  [WORD_WIDTH-1:0] MemData,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_done,
  output logic                  cpu_reset
);

  mem_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  load_done_q, load_done_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_ready_q, load_ready_d;

  logic                  load_accept;
  logic                  cpu_write;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic [WORD_WIDTH-1:0] rd_data;

  // load_ready is registered and only high in LOAD, so it doubles as the state test.
  assign load_accept = load_ready_q & load_valid;
  assign cpu_write   = (state_q == RUN) & MemWrite;

  // Next-state, counters and registered outputs derived from the next state.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    load_count_d = load_count_q;
    load_done_d  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d      = LOAD;
          counter_d    = '0;
          load_count_d = '0;
        end
      end
      LOAD: begin
        if (load_accept) begin
          counter_d    = counter_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (load_last || (counter_q == {ADDR_WIDTH{1'b1}})) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cpu_reset_d  = (state_d != RUN);
    load_ready_d = (state_d == LOAD);
  end

  // Controller registers; reset drops back to IDLE without touching the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      load_count_q <= '0;
      load_done_q  <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      load_count_q <= load_count_d;
      load_done_q  <= load_done_d;
      cpu_reset_q  <= cpu_reset_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Write port mux: host load words take the counter address, processor writes
  // store only the low byte with the upper bits cleared.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = Adr;
    wr_data = {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, MemData[DATA_WIDTH-1:0]};
    if (load_accept) begin
      wr_en   = 1'b1;
      wr_addr = counter_q;
      wr_data = load_data;
    end else if (cpu_write) begin
      wr_en   = 1'b1;
    end
  end

  hmmm_mem_array u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (Adr),
    .rd_data (rd_data)
  );

  assign MemData    = MemWrite ? {WORD_WIDTH{1'bz}} : rd_data;
  assign load_ready = load_ready_q;
  assign load_count = load_count_q;
  assign load_done  = load_done_q;
  assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_hmmm_memory.sv
// Directed plus randomized bench for hmmm_memory against a behavioural model.
module tb_hmmm_memory;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [7:0]  Adr;
  wire  [14:0] MemData;
  logic        load_start;
  logic        load_valid;
  logic [14:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [8:0]  load_count;
  logic        load_done;
  logic        cpu_reset;

  logic        tb_drive_en;
  logic [14:0] tb_bus;

  int checks;
  int errors;

  // Behavioural model: memory image plus load bookkeeping.
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  logic [14:0] ref_mem   [256];
  bit          ref_known [256];
  int          m_mode;
  int          m_ptr;
  int          m_count;
  bit          m_done;

  assign MemData = tb_drive_en ? tb_bus : 15'bz;

  hmmm_memory dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Adr        (Adr),
    .MemData    (MemData),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_count (load_count),
    .load_done  (load_done),
    .cpu_reset  (cpu_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_ptr   = 0;
    m_count = 0;
    m_done  = 0;
  endtask

  // Apply the rules of one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit was_run;
    was_run = (m_mode == M_RUN);
    m_done  = 0;
    if (m_mode == M_LOAD) begin
      if (load_valid) begin
        ref_mem[m_ptr]   = load_data;
        ref_known[m_ptr] = 1;
        m_ptr++;
        m_count++;
        if (load_last || m_ptr == 256) begin
          m_mode = M_RUN;
          m_done = 1;
        end
      end
    end else begin
      if (was_run && MemWrite) begin
        ref_mem[Adr]   = {7'b0, tb_bus[7:0]};
        ref_known[Adr] = 1;
      end
      if (load_start) begin
        m_mode  = M_LOAD;
        m_ptr   = 0;
        m_count = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".cpu_reset"},  cpu_reset,  (m_mode != M_RUN));
    check({tag, ".load_ready"}, load_ready, (m_mode == M_LOAD));
    check({tag, ".load_done"},  load_done,  m_done);
    check({tag, ".load_count"}, load_count, m_count);
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr);
    Adr         = addr;
    MemWrite    = 1'b0;
    tb_drive_en = 1'b0;
    #1;
    if (ref_known[addr]) check(tag, MemData, ref_mem[addr]);
  endtask

  task automatic idle_inputs();
    MemWrite    = 1'b0;
    tb_drive_en = 1'b0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_last   = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [14:0] val);
    Adr         = addr;
    MemWrite    = 1'b1;
    tb_drive_en = 1'b1;
    tb_bus      = val;
  endtask

  initial begin
    logic [14:0] words [3];
    logic [14:0] first_word;
    logic [14:0] last_word;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ref_known[i] = 0;
    words[0] = 15'h1234;
    words[1] = 15'h0ABC;
    words[2] = 15'h7FFF;
    first_word = '0;
    last_word  = '0;

    // Reset and idle
    reset = 1'b1;
    Adr = '0;
    tb_bus = '0;
    load_data = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;
    tick();
    check_outputs("idle");
    cpu_write(8'h40, 15'h2AAA);
    #1;
    check("hiz_bus", MemData, 15'h2AAA);
    tick();
    idle_inputs();

    // Three-word load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_outputs("start3");
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 2);
      tick();
    end
    idle_inputs();
    check_outputs("load3_end");
    check("load3_count", load_count, 9'd3);
    check("load3_done", load_done, 1'b1);
    tick();
    check("load3_done_once", load_done, 1'b0);
    check("load3_cpu_run", cpu_reset, 1'b0);
    read_check("load3_rd1", 8'h01);
    check("load3_rd1_const", MemData, 15'h0ABC);
    read_check("load3_rd0", 8'h00);
    read_check("load3_rd2", 8'h02);

    // Processor write in RUN stores only the low byte
    cpu_write(8'h10, 15'h7FA5);
    tick();
    idle_inputs();
    read_check("run_wr", 8'h10);
    check("run_wr_const", MemData, 15'h00A5);

    // Randomized processor traffic in RUN
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) cpu_write(8'($urandom_range(31, 0)), 15'($urandom));
      else idle_inputs();
      tick();
      idle_inputs();
      read_check("rand_rd", 8'($urandom_range(31, 0)));
    end
    check_outputs("rand_end");

    // 256-word stream with implicit last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_last  = 1'b0;
      load_data  = 15'($urandom);
      if (i == 0)   first_word = load_data;
      if (i == 255) last_word  = load_data;
      tick();
      if (i % 64 == 0) check_outputs("stream_mid");
    end
    idle_inputs();
    check_outputs("stream_end");
    check("stream_count", load_count, 9'd256);
    read_check("stream_ff", 8'hFF);
    check("stream_ff_const", MemData, last_word);
    read_check("stream_00", 8'h00);
    check("stream_00_const", MemData, first_word);

    // Reset in the middle of a five-word load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 15'($urandom);
      tick();
    end
    load_data = 15'($urandom);
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("midreset");
    reset = 1'b0;
    idle_inputs();
    read_check("midreset_rd0", 8'h00);
    read_check("midreset_rd1", 8'h01);
    read_check("midreset_rd2", 8'h02);

    // Processor write while IDLE is ignored
    cpu_write(8'h02, 15'h0055);
    tick();
    idle_inputs();
    read_check("idle_wr_ignored", 8'h02);

    // One-word load to reach RUN, also check MemWrite and load_start ignored in LOAD
    load_start = 1'b1;
    tick();
    idle_inputs();
    cpu_write(8'h30, 15'h0011);
    load_start = 1'b1;
    tick();
    idle_inputs();
    check_outputs("load_ignore");
    read_check("load_wr_ignored", 8'h30);
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 15'($urandom);
    tick();
    idle_inputs();
    check_outputs("one_word_a");

    // load_start from RUN together with a processor write
    cpu_write(8'h20, 15'h00C3);
    load_start = 1'b1;
    tick();
    idle_inputs();
    check_outputs("restart");
    check("restart_cpu_reset", cpu_reset, 1'b1);
    read_check("restart_wr", 8'h20);
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 15'h3C3C;
    tick();
    idle_inputs();
    check_outputs("one_word_b");
    check("one_word_count", load_count, 9'd1);
    read_check("one_word_rd0", 8'h00);
    check("one_word_rd0_const", MemData, 15'h3C3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
